// File: rtl/ntt_stage_seq_pkg.sv
// Shared types and stage-geometry helpers for the NTT/INTT stage sequencer.
// Default stage count, multiplier depth and fifo1 address width live here as overridable macros.
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 3
`endif
`ifndef MUL_STAGE_CNT
`define MUL_STAGE_CNT 4
`endif
`ifndef MAX_FIFO_ADDR_BITS
`define MAX_FIFO_ADDR_BITS 8
`endif

package ntt_stage_seq_pkg;

    localparam int FIFO_ADDR_W = `MAX_FIFO_ADDR_BITS;

    typedef logic [`MAX_FIFO_ADDR_BITS-1:0] fifo_addr_t;

    // log2 of the fifo1 depth: NTT shrinks towards the output, INTT grows.
    function automatic int stage_log2(input int i, input int inv,
                                      input int stages = `NTT_STAGE_CNT);
        return (inv != 0) ? i : (stages - 1 - i);
    endfunction

    function automatic int stage_depth(input int i, input int inv,
                                       input int stages = `NTT_STAGE_CNT);
        return 1 << stage_log2(i, inv, stages);
    endfunction

    // The extra cycle covers the dp_ram output flop.
    function automatic int stage_delay(input int i, input int inv, input int mul_lat,
                                       input int stages = `NTT_STAGE_CNT);
        return stage_depth(i, inv, stages) + mul_lat + 1;
    endfunction

endpackage

// File: rtl/ntt_stage_seq_if.sv
// Bundle between the stage sequencer and its consumers (fifo_cts, dp_ram delay lines).
// slave = sequencer side, master = stimulus / consumer side.
interface ntt_stage_seq_if
    import ntt_stage_seq_pkg::*;
#(
    parameter int STAGES = `NTT_STAGE_CNT
);
    logic                     in_valid;
    logic       [STAGES-1:0]  stage_valid;
    fifo_addr_t [STAGES-1:0]  fifo1_addr;
    logic       [STAGES-1:0]  sw_sel;
    logic       [STAGES-1:0]  fifo_en;
    logic                     poly_done;

    modport master (
        output in_valid,
        input  stage_valid, fifo1_addr, sw_sel, fifo_en, poly_done
    );

    modport slave (
        input  in_valid,
        output stage_valid, fifo1_addr, sw_sel, fifo_en, poly_done
    );
endinterface

// File: rtl/ntt_stage_seq_track.sv
// Per-stage tracker: valid delay line of D(i) cycles, pair counter, registered fifo1 address/switch select.
// fifo_en is the registered OR of the delay line when NTT_FIFO_GATE_EN is defined, else constant 1 out of reset.
module ntt_stage_track
    import ntt_stage_seq_pkg::*;
#(
    parameter int STAGES  = `NTT_STAGE_CNT,
    parameter int IDX     = 0,
    parameter int INV     = 0,
    parameter int MUL_LAT = `MUL_STAGE_CNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    output logic              vld_o,
    output logic [STAGES-1:0] cnt_o,
    output fifo_addr_t        addr_o,
    output logic              sel_o,
    output logic              en_o
);
    localparam int LOG_D = stage_log2(IDX, INV, STAGES);
    localparam int DLY   = stage_delay(IDX, INV, MUL_LAT, STAGES);

    if (LOG_D > FIFO_ADDR_W) begin : g_width_chk
        $error("ntt_stage_track: stage %0d needs %0d address bits, only %0d available",
               IDX, LOG_D, FIFO_ADDR_W);
    end

    logic [DLY-1:0]    sr_q, sr_d;
    logic [STAGES-1:0] cnt_q, cnt_d;
    fifo_addr_t        addr_q, addr_d;
    logic              sel_q, sel_d;
    logic              en_q, en_d;
    fifo_addr_t        cnt_addr;

    // A single-entry fifo1 has no address bits to decode.
    if (LOG_D == 0) begin : g_addr_const
        assign cnt_addr = '0;
    end else begin : g_addr_cnt
        assign cnt_addr = fifo_addr_t'(cnt_q[LOG_D-1:0]);
    end

    always_comb begin
        sr_d   = {sr_q[DLY-2:0], vld_i};
        cnt_d  = cnt_q;
        addr_d = addr_q;
        sel_d  = sel_q;
        if (vld_i) begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = cnt_addr;
            sel_d  = cnt_q[LOG_D];
        end
`ifdef NTT_FIFO_GATE_EN
        en_d = vld_i | (|sr_q);
`else
        en_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            sel_q  <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            sel_q  <= sel_d;
            en_q   <= en_d;
        end
    end

    assign vld_o  = sr_q[DLY-1];
    assign cnt_o  = cnt_q;
    assign addr_o = addr_q;
    assign sel_o  = sel_q;
    assign en_o   = en_q;
endmodule

// File: rtl/ntt_stage_seq.sv
// NTT/INTT stage sequencer: chains per-stage valid tracking and flags the last pair of each polynomial.
// Optional NTT_FIFO_GATE_EN gates fifo_en to cycles with data in flight; no backpressure, in_valid is never stalled.
module ntt_stage_seq
    import ntt_stage_seq_pkg::*;
#(
    parameter int STAGES  = `NTT_STAGE_CNT,
    parameter int MUL_LAT = `MUL_STAGE_CNT,
    parameter int INV     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    ntt_stage_seq_if.slave bus
);
    logic [STAGES:0]   vld_chain;
    logic [STAGES-1:0] cnt_arr [STAGES];
    fifo_addr_t        addr_arr [STAGES];
    logic [STAGES-1:0] sel_arr;
    logic [STAGES-1:0] en_arr;
    logic              poly_done_q, poly_done_d;

    // Masked so nothing is reported as valid while reset is held.
    assign vld_chain[0] = bus.in_valid & rst_n;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        ntt_stage_track #(
            .STAGES  (STAGES),
            .IDX     (i),
            .INV     (INV),
            .MUL_LAT (MUL_LAT)
        ) u_track (
            .clk    (clk),
            .rst_n  (rst_n),
            .vld_i  (vld_chain[i]),
            .vld_o  (vld_chain[i+1]),
            .cnt_o  (cnt_arr[i]),
            .addr_o (addr_arr[i]),
            .sel_o  (sel_arr[i]),
            .en_o   (en_arr[i])
        );
        assign bus.fifo1_addr[i] = addr_arr[i];
    end

    assign poly_done_d = vld_chain[STAGES-1] & (cnt_arr[STAGES-1] == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poly_done_q <= 1'b0;
        end else begin
            poly_done_q <= poly_done_d;
        end
    end

    assign bus.stage_valid = vld_chain[STAGES-1:0];
    assign bus.sw_sel      = sel_arr;
    assign bus.fifo_en     = en_arr;
    assign bus.poly_done   = poly_done_q;
endmodule
